// File: rtl/led7seg_scan_scheduler_if.sv
// Word stream from the scan scheduler to the 74HC595 shift controller.
// The master drives {segments, select} words; the slave accepts them with rdy.
interface led7seg_scan_scheduler_if;
    logic [15:0] dat;
    logic        vld;
    logic        rdy;

    modport master (output dat, output vld, input rdy);
    modport slave  (input dat, input vld, output rdy);
endinterface

// File: rtl/led7seg_scan_scheduler.sv
// Periodic frame scheduler for the 8-digit seven-segment module: snapshots
// digit codes and masks, then streams one {segments, select} word per digit.
module led7seg_scan_scheduler #(
    parameter int unsigned REFRESH_DIV    = 125000,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            en_i,
    input  logic [31:0]                     digits_i,
    input  logic [7:0]                      blank_i,
    input  logic [7:0]                      dp_i,
    led7seg_scan_scheduler_if.master        out_if,
    output logic                            busy_o,
    output logic                            frame_done_o
);

    localparam int CNT_W = $clog2(REFRESH_DIV);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SEND
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pending_q, pending_d;
    logic [2:0]        idx_q, idx_d;
    logic [15:0]       dat_q, dat_d;
    logic              frame_done_q, frame_done_d;
    logic [31:0]       digits_q;
    logic [7:0]        blank_q;
    logic [7:0]        dp_q;
    logic              tick;
    logic [2:0]        idx_nxt;

    function automatic logic [7:0] seg_lut(input logic [3:0] code);
        logic [7:0] seg;
        case (code)
            4'h0: seg = 8'h3F;
            4'h1: seg = 8'h06;
            4'h2: seg = 8'h5B;
            4'h3: seg = 8'h4F;
            4'h4: seg = 8'h66;
            4'h5: seg = 8'h6D;
            4'h6: seg = 8'h7D;
            4'h7: seg = 8'h07;
            4'h8: seg = 8'h7F;
            4'h9: seg = 8'h6F;
            4'hA: seg = 8'h77;
            4'hB: seg = 8'h7C;
            4'hC: seg = 8'h39;
            4'hD: seg = 8'h5E;
            4'hE: seg = 8'h79;
            default: seg = 8'h71;
        endcase
        return seg;
    endfunction

    // Blank wins over dp; polarity is applied last and never touches select.
    function automatic logic [15:0] encode(input logic [3:0] code, input logic blank,
                                           input logic dp, input logic [2:0] idx);
        logic [7:0] seg;
        seg    = seg_lut(code);
        seg[7] = dp;
        if (blank) seg = 8'h00;
        if (SEG_ACTIVE_LOW) seg = ~seg;
        return {seg, 8'h01 << idx};
    endfunction

    assign tick    = (cnt_q == CNT_W'(REFRESH_DIV - 1));
    assign cnt_d   = tick ? '0 : cnt_q + 1'b1;
    assign idx_nxt = idx_q + 3'd1;

    assign out_if.dat   = dat_q;
    assign out_if.vld   = (state_q == S_SEND);
    assign busy_o       = (state_q != S_IDLE);
    assign frame_done_o = frame_done_q;

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path infers a latch.
        state_d      = state_q;
        pending_d    = pending_q;
        idx_d        = idx_q;
        dat_d        = dat_q;
        frame_done_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (tick && en_i) state_d = S_LOAD;
            end

            S_LOAD: begin
                idx_d   = 3'd0;
                dat_d   = encode(digits_i[3:0], blank_i[0], dp_i[0], 3'd0);
                state_d = S_SEND;
                if (tick) pending_d = 1'b1;
            end

            S_SEND: begin
                if (tick) pending_d = 1'b1;
                if (out_if.rdy) begin
                    if (idx_q != 3'd7) begin
                        idx_d = idx_nxt;
                        dat_d = encode(digits_q[{idx_nxt, 2'b00} +: 4], blank_q[idx_nxt],
                                       dp_q[idx_nxt], idx_nxt);
                    end else begin
                        // A tick landing on the final transfer starts the next frame directly.
                        frame_done_d = 1'b1;
                        pending_d    = 1'b0;
                        state_d      = ((pending_q || tick) && en_i) ? S_LOAD : S_IDLE;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            pending_q    <= 1'b0;
            idx_q        <= 3'd0;
            dat_q        <= 16'h0000;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pending_q    <= pending_d;
            idx_q        <= idx_d;
            dat_q        <= dat_d;
            frame_done_q <= frame_done_d;
        end
    end

    // NOTE: the snapshot needs no reset; it is always written in LOAD before SEND reads it.
    always_ff @(posedge clk) begin
        if (state_q == S_LOAD) begin
            digits_q <= digits_i;
            blank_q  <= blank_i;
            dp_q     <= dp_i;
        end
    end

endmodule

// File: tb/tb_led7seg_scan_scheduler.sv
// Self-checking bench: two scheduler instances (both segment polarities) driven
// identically and compared every cycle against a frame-level reference model.
module tb_led7seg_scan_scheduler;

    localparam int DIV = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en;
    logic [31:0] digits;
    logic [7:0]  blank;
    logic [7:0]  dp;
    logic        busy0, busy1, fd0, fd1;

    led7seg_scan_scheduler_if if0 ();
    led7seg_scan_scheduler_if if1 ();

    led7seg_scan_scheduler #(.REFRESH_DIV(DIV), .SEG_ACTIVE_LOW(1'b0)) dut0 (
        .clk(clk), .rst(rst), .en_i(en), .digits_i(digits), .blank_i(blank), .dp_i(dp),
        .out_if(if0), .busy_o(busy0), .frame_done_o(fd0)
    );

    led7seg_scan_scheduler #(.REFRESH_DIV(DIV), .SEG_ACTIVE_LOW(1'b1)) dut1 (
        .clk(clk), .rst(rst), .en_i(en), .digits_i(digits), .blank_i(blank), .dp_i(dp),
        .out_if(if1), .busy_o(busy1), .frame_done_o(fd1)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: phase -1 idle, 0 loading, 1..8 presenting digit phase-1.
    logic [6:0]  seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    logic [3:0]  s_code [8];
    bit          s_blank [8];
    bit          s_dp [8];
    int          m_cyc, m_phase, m_frames, dut_frames;
    bit          m_pending, m_done;
    logic [15:0] m_dat0, m_dat1;
    logic [15:0] xfer_q [$];

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_word(input bit sal, input int i);
        logic [7:0] seg, sel;
        seg = {s_dp[i], seg_tab[s_code[i]]};
        if (s_blank[i]) seg = 8'h00;
        if (sal) seg = ~seg;
        sel    = 8'h00;
        sel[i] = 1'b1;
        return {seg, sel};
    endfunction

    task automatic model_reset();
        m_cyc     = 0;
        m_phase   = -1;
        m_pending = 1'b0;
        m_done    = 1'b0;
        m_dat0    = 16'h0000;
        m_dat1    = 16'h0000;
    endtask

    // Advance the model across one clock edge using the pre-edge inputs.
    task automatic model_edge(input bit r);
        bit tick;
        bit last_xfer;
        tick      = (m_cyc == DIV - 1);
        m_cyc     = (m_cyc + 1) % DIV;
        m_done    = 1'b0;
        last_xfer = (m_phase == 8) && r;
        if (m_phase == -1) begin
            if (tick && en) m_phase = 0;
        end else if (m_phase == 0) begin
            for (int i = 0; i < 8; i++) begin
                s_code[i]  = digits[4*i +: 4];
                s_blank[i] = blank[i];
                s_dp[i]    = dp[i];
            end
            if (tick) m_pending = 1'b1;
            m_phase = 1;
        end else if (last_xfer) begin
            m_done = 1'b1;
            m_frames++;
            m_phase   = ((m_pending || tick) && en) ? 0 : -1;
            m_pending = 1'b0;
        end else begin
            if (tick) m_pending = 1'b1;
            if (r) m_phase++;
        end
        if (m_phase >= 1) begin
            m_dat0 = exp_word(1'b0, m_phase - 1);
            m_dat1 = exp_word(1'b1, m_phase - 1);
        end
    endtask

    task automatic step(input bit r);
        if0.rdy = r;
        if1.rdy = r;
        if (if0.vld && r) xfer_q.push_back(if0.dat);
        model_edge(r);
        @(posedge clk);
        #1;
        if (fd0) dut_frames++;
        check("vld0",  16'(if0.vld), 16'(m_phase >= 1));
        check("vld1",  16'(if1.vld), 16'(m_phase >= 1));
        check("dat0",  if0.dat, m_dat0);
        check("dat1",  if1.dat, m_dat1);
        check("busy0", 16'(busy0), 16'(m_phase >= 0));
        check("busy1", 16'(busy1), 16'(m_phase >= 0));
        check("fd0",   16'(fd0), 16'(m_done));
        check("fd1",   16'(fd1), 16'(m_done));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_vld0", 16'(if0.vld), 16'h0);
        check("rst_dat0", if0.dat, 16'h0000);
        check("rst_vld1", 16'(if1.vld), 16'h0);
        check("rst_dat1", if1.dat, 16'h0000);
        check("rst_busy", 16'({busy0, busy1}), 16'h0);
        check("rst_fd",   16'({fd0, fd1}), 16'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_phase(input int p, input int bound);
        for (int k = 0; k < bound && m_phase != p; k++) step(1'b1);
        check("wait_phase", 16'(m_phase), 16'(p));
    endtask

    logic [15:0] tab0 [8] = '{16'hBF01, 16'h0602, 16'h5B04, 16'h4F08,
                              16'h6610, 16'h6D20, 16'h7D40, 16'h0080};
    logic [15:0] tab1 [8] = '{16'h4001, 16'hF902, 16'hA404, 16'hB008,
                              16'h9910, 16'h9220, 16'h8240, 16'hFF80};

    initial begin
        int          n, f0, vld_seen;
        bit          stalled;
        logic [15:0] held;

        en         = 1'b1;
        digits     = 32'h7654_3210;
        blank      = 8'h80;
        dp         = 8'h01;
        if0.rdy    = 1'b1;
        if1.rdy    = 1'b1;
        m_frames   = 0;
        dut_frames = 0;
        #3;
        do_reset();

        // First frame: tick on the DIV-th edge, LOAD, then digit 0 one edge later.
        n = 0;
        for (int k = 0; k < 40 && !if0.vld; k++) begin
            step(1'b1);
            n++;
        end
        check("first_vld_latency", 16'(n), 16'(DIV + 1));
        for (int k = 0; k < 8; k++) begin
            check("dir_word0", if0.dat, tab0[k]);
            check("dir_word1", if1.dat, tab1[k]);
            step(1'b1);
        end
        check("dir_frame_done", 16'(fd0), 16'h1);

        // Random rdy with a 5-cycle stall on digit 3.
        wait_phase(0, 40);
        xfer_q.delete();
        stalled = 1'b0;
        f0      = m_frames;
        for (int k = 0; k < 200 && m_frames == f0; k++) begin
            if (m_phase == 4 && !stalled) begin
                stalled = 1'b1;
                held    = if0.dat;
                repeat (5) begin
                    step(1'b0);
                    check("stall_dat", if0.dat, held);
                    check("stall_vld", 16'(if0.vld), 16'h1);
                end
            end else begin
                step(1'($urandom_range(0, 1)));
            end
        end
        check("stall_xfers", 16'(xfer_q.size()), 16'd8);
        for (int k = 0; k < 8 && k < xfer_q.size(); k++)
            check("stall_order", 16'(xfer_q[k][7:0]), 16'(8'h01 << k));

        // Inputs changed after LOAD must not tear the frame in flight.
        digits = 32'h1111_1111;
        blank  = 8'h00;
        dp     = 8'h00;
        wait_phase(0, 40);
        xfer_q.delete();
        step(1'b1);
        step(1'b1);
        digits = 32'h2222_2222;
        f0     = m_frames;
        for (int k = 0; k < 40 && m_frames == f0; k++) step(1'b1);
        check("snap1_xfers", 16'(xfer_q.size()), 16'd8);
        for (int k = 0; k < xfer_q.size(); k++) check("snap1_seg", 16'(xfer_q[k][15:8]), 16'h06);
        wait_phase(0, 40);
        xfer_q.delete();
        f0 = m_frames;
        for (int k = 0; k < 40 && m_frames == f0; k++) step(1'b1);
        check("snap2_xfers", 16'(xfer_q.size()), 16'd8);
        for (int k = 0; k < xfer_q.size(); k++) check("snap2_seg", 16'(xfer_q[k][15:8]), 16'h5B);

        // Overrun: long stall collects ticks; the next LOAD follows frame_done directly.
        digits = 32'hFEDC_BA98;
        wait_phase(1, 40);
        repeat (40) step(1'b0);
        for (int k = 0; k < 40 && !fd0; k++) step(1'b1);
        check("ovr_done", 16'(fd0), 16'h1);
        check("ovr_reload_busy", 16'(busy0), 16'h1);
        check("ovr_reload_vld", 16'(if0.vld), 16'h0);
        check("ovr_frames", 16'(dut_frames), 16'(m_frames));

        // en dropped mid-frame: frame completes, then the display goes quiet.
        wait_phase(3, 40);
        en = 1'b0;
        for (int k = 0; k < 40 && !fd0; k++) step(1'b1);
        check("en_off_done", 16'(fd0), 16'h1);
        vld_seen = 0;
        repeat (60) begin
            step(1'b1);
            if (if0.vld) vld_seen++;
        end
        check("en_off_vld", 16'(vld_seen), 16'h0);
        check("en_off_busy", 16'(busy0), 16'h0);
        en = 1'b1;

        // Reset mid-SEND abandons the frame; the next one begins at digit 0.
        wait_phase(5, 60);
        do_reset();
        for (int k = 0; k < 40 && !if0.vld; k++) step(1'b1);
        check("post_rst_vld", 16'(if0.vld), 16'h1);
        check("post_rst_sel", 16'(if0.dat[7:0]), 16'h01);

        // Randomized traffic against the model.
        for (int k = 0; k < 1500; k++) begin
            en     = ($urandom_range(0, 9) != 0);
            digits = $urandom;
            blank  = 8'($urandom);
            dp     = 8'($urandom);
            step(($urandom_range(0, 9) < 7));
        end
        check("total_frames", 16'(dut_frames), 16'(m_frames));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
